shared_bus_arbiter: RTL and testbench

- Round-robin arbiter and transaction sequencer for the snooping shared bus between L2Cache instances and memory.
- Accepts bus requests from N caches and grants exactly one.
- Broadcasts the winner's operation and address.
- Collects and reduces snoop responses from the other caches, then holds the bus until the data phase completes.
- Replaces the ad-hoc shared-bus driving currently done in the test bench.

---
 rtl/shared_bus_pkg.sv | 21 ++
 rtl/rr_picker.sv | 31 +++
 rtl/shared_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_shared_bus_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_bus_pkg.sv
// Shared snooping-bus types: snoop reply codes, sequencer states, bus op codes.
// No logic; combinational helper only.
package shared_bus_pkg;

  localparam logic [1:0] SNOOP_HIT   = 2'b00;
  localparam logic [1:0] SNOOP_HITM  = 2'b01;
  localparam logic [1:0] SNOOP_NOHIT = 2'b10;

  typedef enum logic [2:0] {IDLE, ARB, ADDR, SNOOP, DATA, DONE} busState_t;

  // Operation codes also decoded by L2Cache.
  localparam logic [7:0] BUS_RD   = 8'h01;
  localparam logic [7:0] BUS_RDX  = 8'h02;
  localparam logic [7:0] BUS_UPGR = 8'h03;
  localparam logic [7:0] BUS_WB   = 8'h04;

  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin one-hot select: first asserted req at or after pointer, wrapping.
// Latency: combinational. Backpressure: none.
// Backpressure: none; the caller holds req until it is served.
module rr_picker #(
  parameter int numReq = 4,
  parameter int ptrW   = 2
) (
  input  logic [numReq-1:0] req,
  input  logic [ptrW-1:0]   pointer,
  output logic [numReq-1:0] grantOh,
  output logic [ptrW-1:0]   grantIdx
);

  always_comb begin
    int  idx;
    logic found;
    grantOh  = '0;
    grantIdx = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < numReq; k++) begin
      idx = (int'(pointer) + k) % numReq;
      if (!found && req[idx]) begin
        found        = 1'b1;
        grantOh[idx] = 1'b1;
        grantIdx     = ptrW'(idx);
      end
    end
  end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter/sequencer for the snooping shared bus (ARB, ADDR, SNOOP, DATA, DONE).
// Latency: req to busValid 2 cycles from IDLE; minimum transaction 4+snoopWait cycles.
// Backpressure: bus held until dataDone; SHARED_BUS_STATS_EN adds saturating stat counters.
module shared_bus_arbiter
  import shared_bus_pkg::*;
#(
  parameter int numReq      = 4,
  parameter int commandSize = 8,
  parameter int addressSize = 32,
  parameter int snoopWait   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [numReq-1:0]             req,
  input  logic [numReq*commandSize-1:0] opIn,
  input  logic [numReq*addressSize-1:0] addrIn,
  input  logic [numReq*2-1:0]           snoopIn,
  input  logic                          dataDone,
  output logic [numReq-1:0]             grant,
  output logic [commandSize-1:0]        busOp,
  output logic [addressSize-1:0]        busAddr,
  output logic                          busValid,
  output logic [1:0]                    snoopResult,
  output logic                          snoopValid,
  output logic                          txnDone,
  output logic                          busy
`ifdef SHARED_BUS_STATS_EN
  ,
  output logic [31:0]                   grantCount,
  output logic [31:0]                   hitmCount,
  output logic [31:0]                   busCycles
`endif
);

  localparam int ptrW = (numReq > 1) ? $clog2(numReq) : 1;

  busState_t              state, nextState;
  logic [ptrW-1:0]        pointer, winIdx, pickIdx;
  logic [numReq-1:0]      pickOh;
  logic [3:0]             snoopCnt;
  logic [commandSize-1:0] opReg;
  logic [addressSize-1:0] addrReg;
  logic [1:0]             snoopReduced;
  logic                   snoopLast, othersReq;

  rr_picker #(.numReq(numReq), .ptrW(ptrW)) uPicker (
    .req     (req),
    .pointer (pointer),
    .grantOh (pickOh),
    .grantIdx(pickIdx)
  );

  assign snoopLast = (snoopCnt == 4'(snoopWait - 1));
  assign othersReq = |(req & ~grant);
  assign busOp     = opReg;
  assign busAddr   = addrReg;
  assign busValid  = (state == ADDR);
  assign txnDone   = (state == DONE);
  assign busy      = (state != IDLE);

  // The winner's own reply is excluded; code 11 falls through as NOHIT.
  always_comb begin
    logic anyHit, anyHitm;
    anyHit  = 1'b0;
    anyHitm = 1'b0;
    for (int i = 0; i < numReq; i++) begin
      if (ptrW'(i) != winIdx) begin
        if (snoopIn[2*i +: 2] == SNOOP_HITM) anyHitm = 1'b1;
        if (snoopIn[2*i +: 2] == SNOOP_HIT)  anyHit  = 1'b1;
      end
    end
    snoopReduced = anyHitm ? SNOOP_HITM : (anyHit ? SNOOP_HIT : SNOOP_NOHIT);
  end

  // DATA is entered together with the snoopValid pulse, so dataDone in that cycle ends it.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (|req) nextState = ARB;
      ARB:     nextState = (|req) ? ADDR : IDLE;
      ADDR:    nextState = SNOOP;
      SNOOP:   if (snoopLast) nextState = DATA;
      DATA:    if (dataDone) nextState = DONE;
      DONE:    nextState = othersReq ? ARB : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pointer     <= '0;
      winIdx      <= '0;
      grant       <= '0;
      opReg       <= '0;
      addrReg     <= '0;
      snoopCnt    <= '0;
      snoopResult <= 2'b00;
      snoopValid  <= 1'b0;
    end else begin
      state      <= nextState;
      snoopValid <= 1'b0;
      case (state)
        ARB: if (|req) begin
          grant   <= pickOh;
          winIdx  <= pickIdx;
          opReg   <= opIn[pickIdx*commandSize +: commandSize];
          addrReg <= addrIn[pickIdx*addressSize +: addressSize];
        end
        ADDR: snoopCnt <= '0;
        SNOOP: begin
          snoopCnt <= snoopCnt + 4'd1;
          if (snoopLast) begin
            snoopResult <= snoopReduced;
            snoopValid  <= 1'b1;
          end
        end
        DONE: begin
          grant   <= '0;
          opReg   <= '0;
          addrReg <= '0;
          pointer <= (winIdx == ptrW'(numReq - 1)) ? '0 : winIdx + ptrW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SHARED_BUS_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grantCount <= '0;
      hitmCount  <= '0;
      busCycles  <= '0;
    end else begin
      if (state == ARB) grantCount <= satInc(grantCount);
      if (snoopValid && snoopResult == SNOOP_HITM) hitmCount <= satInc(hitmCount);
      if (busy) busCycles <= satInc(busCycles);
    end
  end
`endif

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Bench for shared_bus_arbiter: dut (snoopWait=2) and dut1 (snoopWait=1), scoreboarded grants/snoops.
// Stats checks compile in with SHARED_BUS_STATS_EN.
module tb_shared_bus_arbiter;
  import shared_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset, dataDone, reset1, dataDone1;
  logic [3:0]  req, req1;
  logic [31:0] opIn, opIn1;
  logic [127:0] addrIn, addrIn1;
  logic [7:0]  snoopIn, snoopIn1;
  logic [3:0]  grant, grant1;
  logic [7:0]  busOp, busOp1;
  logic [31:0] busAddr, busAddr1;
  logic [1:0]  snoopResult, snoopResult1;
  logic        busValid, snoopValid, txnDone, busy;
  logic        busValid1, snoopValid1, txnDone1, busy1;
`ifdef SHARED_BUS_STATS_EN
  logic [31:0] grantCount, hitmCount, busCycles, grantCount1, hitmCount1, busCycles1;
`endif

  int nCompared = 0;
  int nMismatch = 0;
  logic [3:0] expGrant[$];
  logic [1:0] expSnoop[$];

  always #5 clk = ~clk;

  shared_bus_arbiter #(.numReq(4), .commandSize(8), .addressSize(32), .snoopWait(2)) dut (
    .clk(clk), .reset(reset), .req(req), .opIn(opIn), .addrIn(addrIn), .snoopIn(snoopIn),
    .dataDone(dataDone), .grant(grant), .busOp(busOp), .busAddr(busAddr), .busValid(busValid),
    .snoopResult(snoopResult), .snoopValid(snoopValid), .txnDone(txnDone), .busy(busy)
`ifdef SHARED_BUS_STATS_EN
    , .grantCount(grantCount), .hitmCount(hitmCount), .busCycles(busCycles)
`endif
  );

  shared_bus_arbiter #(.numReq(4), .commandSize(8), .addressSize(32), .snoopWait(1)) dut1 (
    .clk(clk), .reset(reset1), .req(req1), .opIn(opIn1), .addrIn(addrIn1), .snoopIn(snoopIn1),
    .dataDone(dataDone1), .grant(grant1), .busOp(busOp1), .busAddr(busAddr1), .busValid(busValid1),
    .snoopResult(snoopResult1), .snoopValid(snoopValid1), .txnDone(txnDone1), .busy(busy1)
`ifdef SHARED_BUS_STATS_EN
    , .grantCount(grantCount1), .hitmCount(hitmCount1), .busCycles(busCycles1)
`endif
  );

  // Bounded wait on a DUT pulse; returns at the negedge where it is seen.
  task automatic waitFor(input int sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      case (sel)
        0:       ok = busValid;
        1:       ok = snoopValid;
        2:       ok = txnDone;
        3:       ok = busValid1;
        default: ok = 1'b0;
      endcase
      if (ok) break;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0; dataDone = 1'b0; snoopIn = 8'hAA; opIn = '0; addrIn = '0;
    @(negedge clk);
    @(negedge clk);
    nCompared++;
    if ({grant, busOp, busAddr, busValid, snoopResult, snoopValid, txnDone, busy} !== '0) begin
      nMismatch++;
      $display("FAIL reset_outputs got grant=%b op=%h addr=%h bv=%b sr=%b sv=%b td=%b busy=%b want all 0",
               grant, busOp, busAddr, busValid, snoopResult, snoopValid, txnDone, busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    logic [3:0] eg;
    logic [1:0] es;
    doReset();
    opIn[15:8] = BUS_RD;
    addrIn[63:32] = 32'h0000_1040;
    snoopIn = 8'hAA;
    req = 4'b0010;
    expGrant.push_back(4'b0010);
    expSnoop.push_back(SNOOP_NOHIT);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      nCompared++;
      if ({busValid, snoopValid, txnDone, busy} !== {c == 2, c == 5, c == 8, c <= 8}) begin
        nMismatch++;
        $display("FAIL single_timing cycle %0d got bv/sv/td/busy=%b%b%b%b want %b%b%b%b", c,
                 busValid, snoopValid, txnDone, busy, c == 2, c == 5, c == 8, c <= 8);
      end
      if (c == 2) begin
        eg = expGrant.pop_front();
        nCompared++;
        if (grant !== eg || busOp !== BUS_RD || busAddr !== 32'h0000_1040) begin
          nMismatch++;
          $display("FAIL single_addr got grant=%b op=%h addr=%h want %b 01 00001040", grant, busOp, busAddr, eg);
        end
      end
      if (c == 5) begin
        es = expSnoop.pop_front();
        nCompared++;
        if (snoopResult !== es) begin
          nMismatch++;
          $display("FAIL single_snoop got %b want %b", snoopResult, es);
        end
      end
      if (c == 7) dataDone = 1'b1;
      if (c == 8) begin dataDone = 1'b0; req = '0; end
    end
    // Pointer must now be 2: 0110 resolves to requester 2, not 1.
    req = 4'b0110;
    expGrant.push_back(4'b0100);
    waitFor(0, ok);
    eg = expGrant.pop_front();
    nCompared++;
    if (!ok || grant !== eg) begin
      nMismatch++;
      $display("FAIL single_pointer got ok=%b grant=%b want grant %b", ok, grant, eg);
    end
    dataDone = 1'b1;
    waitFor(2, ok);
    req = '0; dataDone = 1'b0;
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [3:0] eg;
    int ei;
    doReset();
    for (int i = 0; i < 4; i++) begin
      opIn[i*8 +: 8]    = BUS_RD + 8'(i);
      addrIn[i*32 +: 32] = 32'h1000 * (i + 1);
    end
    snoopIn = 8'hAA;
    dataDone = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) expGrant.push_back(4'b0001 << (i % 4));
    for (int t = 0; t < 5; t++) begin
      waitFor(0, ok);
      eg = expGrant.pop_front();
      ei = 0;
      for (int b = 0; b < 4; b++) if (eg[b]) ei = b;
      nCompared++;
      if (!ok || grant !== eg || busOp !== BUS_RD + 8'(ei) || busAddr !== 32'h1000 * (ei + 1)) begin
        nMismatch++;
        $display("FAIL rr_grant txn %0d got ok=%b grant=%b op=%h addr=%h want grant %b", t, ok, grant, busOp, busAddr, eg);
      end
    end
    // Dropping req after grant is not an abort.
    req = '0;
    waitFor(2, ok);
    nCompared++;
    if (!ok) begin
      nMismatch++;
      $display("FAIL rr_drop_req got no txnDone want txnDone");
    end
    @(negedge clk);
    nCompared++;
    if (busy !== 1'b0) begin
      nMismatch++;
      $display("FAIL rr_idle got busy=%b want 0", busy);
    end
    dataDone = 1'b0;
  endtask

  task automatic test_snoop_reduce();
    bit ok;
    logic [1:0] es;
    logic [7:0] pat [4] = '{8'b00_01_00_10, 8'b10_10_10_01, 8'b11_10_00_01, 8'b11_11_11_00};
    logic [1:0] res [4] = '{SNOOP_HITM, SNOOP_NOHIT, SNOOP_HIT, SNOOP_NOHIT};
    doReset();
    dataDone = 1'b1;
    snoopIn = pat[0];
    req = 4'b0001;
    for (int i = 0; i < 4; i++) expSnoop.push_back(res[i]);
    for (int t = 0; t < 4; t++) begin
      waitFor(1, ok);
      es = expSnoop.pop_front();
      nCompared++;
      if (!ok || snoopResult !== es || grant !== 4'b0001) begin
        nMismatch++;
        $display("FAIL snoop_reduce pat %b got ok=%b res=%b grant=%b want res %b grant 0001", pat[t], ok, snoopResult, grant, es);
      end
      if (t < 3) snoopIn = pat[t+1];
    end
    waitFor(2, ok);
    req = '0; dataDone = 1'b0; snoopIn = 8'hAA;
    @(negedge clk);
  endtask

  task automatic test_datadone_held();
    bit ok;
    @(negedge clk);
    reset1 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      nCompared++;
      if (busy1 !== 1'b0) begin
        nMismatch++;
        $display("FAIL held_idle cycle %0d got busy=%b want 0", c, busy1);
      end
    end
    req1 = 4'b0100;
    waitFor(3, ok);
    nCompared++;
    if (!ok || grant1 !== 4'b0100) begin
      nMismatch++;
      $display("FAIL held_addr got ok=%b grant=%b want 0100", ok, grant1);
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      nCompared++;
      if ({snoopValid1, txnDone1, busy1} !== {c == 2, c == 3, c <= 3}) begin
        nMismatch++;
        $display("FAIL held_data cycle %0d got sv/td/busy=%b%b%b want %b%b%b", c,
                 snoopValid1, txnDone1, busy1, c == 2, c == 3, c <= 3);
      end
      if (c == 3) req1 = '0;
    end
  endtask

  task automatic test_reset_mid_data();
    bit ok;
    doReset();
    snoopIn = 8'hAA;
    dataDone = 1'b1;
    req = 4'b0010;
    waitFor(2, ok);
    req = 4'b0100;
    dataDone = 1'b0;
    waitFor(1, ok);
    reset = 1'b1;
    @(negedge clk);
    nCompared++;
    if (!ok || grant !== 4'b0000 || busy !== 1'b0 || txnDone !== 1'b0) begin
      nMismatch++;
      $display("FAIL reset_mid_data got ok=%b grant=%b busy=%b td=%b want 0000 0 0", ok, grant, busy, txnDone);
    end
    reset = 1'b0;
    expGrant.push_back(4'b0100);
    waitFor(0, ok);
    nCompared++;
    if (!ok || grant !== expGrant.pop_front()) begin
      nMismatch++;
      $display("FAIL reset_restart got ok=%b grant=%b want 0100", ok, grant);
    end
    dataDone = 1'b1;
    waitFor(2, ok);
    req = '0;
    // Pointer is 3 here; a reset must bring it back to 0.
    doReset();
    req = 4'b1001;
    waitFor(0, ok);
    nCompared++;
    if (!ok || grant !== 4'b0001) begin
      nMismatch++;
      $display("FAIL reset_pointer got ok=%b grant=%b want 0001", ok, grant);
    end
    waitFor(2, ok);
    req = '0; dataDone = 1'b0;
    @(negedge clk);
  endtask

`ifdef SHARED_BUS_STATS_EN
  task automatic test_stats();
    bit ok;
    doReset();
    nCompared++;
    if ({grantCount, hitmCount, busCycles} !== '0) begin
      nMismatch++;
      $display("FAIL stats_reset got %0d %0d %0d want 0 0 0", grantCount, hitmCount, busCycles);
    end
    snoopIn = 8'hAA;
    dataDone = 1'b1;
    req = 4'b0001;
    for (int t = 0; t < 3; t++) begin
      waitFor(2, ok);
      snoopIn = (t == 0) ? 8'b10_10_01_10 : 8'hAA;
    end
    req = '0;
    dataDone = 1'b0;
    @(negedge clk);
    // Three 6-cycle transactions (4 + snoopWait) separated by non-busy IDLE cycles.
    nCompared++;
    if (!ok || grantCount !== 32'd3 || hitmCount !== 32'd1 || busCycles !== 32'd18) begin
      nMismatch++;
      $display("FAIL stats_counts got ok=%b grant=%0d hitm=%0d cycles=%0d want 3 1 18", ok, grantCount, hitmCount, busCycles);
    end
  endtask
`endif

  initial begin
    reset1 = 1'b1; req1 = '0; dataDone1 = 1'b1; opIn1 = '0; addrIn1 = '0; snoopIn1 = 8'hAA;
    test_reset();
    test_single();
    test_round_robin();
    test_snoop_reduce();
    test_datadone_held();
    test_reset_mid_data();
`ifdef SHARED_BUS_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
